// File: rtl/decode_stage.sv
// Decode stage of the 3-stage pipeline: ID/EX register, 16x16 register file with
// write-back bypass, back-pressure, branch flush and HALT handling.
module decode_stage #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8,
  parameter int NREG   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [15:0]       curr_instr,
  input  logic [ADDR_W-1:0] instr_addr,
  input  logic              if_valid,
  output logic              dec_stall,
  input  logic              ex_ready,
  input  logic              flush,
  input  logic              wb_en,
  input  logic [3:0]        wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  output logic              id_valid,
  output logic [3:0]        id_op,
  output logic [3:0]        id_rd,
  output logic [DATA_W-1:0] id_a,
  output logic [DATA_W-1:0] id_b,
  output logic              id_we,
  output logic              id_jmp,
  output logic [ADDR_W-1:0] id_target,
  output logic [ADDR_W-1:0] id_pc,
  output logic              id_illegal,
  output logic              halted
);

  typedef enum logic [0:0] {RUN = 1'b0, HALTED = 1'b1} state_t;

  state_t              state_r, state_nxt_s;
  logic [DATA_W-1:0]   regs_r [NREG];

  logic                id_valid_r, id_we_r, id_jmp_r, id_illegal_r;
  logic [3:0]          id_op_r, id_rd_r;
  logic [DATA_W-1:0]   id_a_r, id_b_r;
  logic [ADDR_W-1:0]   id_target_r, id_pc_r;

  logic [3:0]          op_s, rd_s, rs1_s, rs2_s;
  logic [DATA_W-1:0]   a_s, b_s;
  logic                we_s, jmp_s, illegal_s, accept_s;
  logic [ADDR_W-1:0]   target_s;

  // Register read port: R0 is hard zero, a same-cycle write-back wins over the array.
  function automatic logic [DATA_W-1:0] read_port(input logic [3:0] idx);
    if (idx == 4'd0) begin
      return {DATA_W{1'b0}};
    end else if (wb_en && (wb_rd == idx)) begin
      return wb_data;
    end else begin
      return regs_r[idx];
    end
  endfunction

  assign dec_stall = (id_valid_r & ~ex_ready) | (state_r == HALTED);
  assign accept_s  = if_valid & ~dec_stall & ~flush & (state_r == RUN);

  // Field decode and operand selection for the instruction presented by fetch.
  always_comb begin
    op_s      = curr_instr[15:12];
    rd_s      = curr_instr[11:8];
    rs1_s     = curr_instr[7:4];
    rs2_s     = curr_instr[3:0];
    a_s       = read_port(rs1_s);
    b_s       = read_port(rs2_s);
    we_s      = 1'b0;
    jmp_s     = 1'b0;
    illegal_s = 1'b0;
    target_s  = {ADDR_W{1'b0}};
    case (op_s)
      4'h0: begin
        we_s = 1'b0;
      end
      4'h1, 4'h2, 4'h3, 4'h4, 4'h5: begin
        we_s = (rd_s != 4'd0);
      end
      4'h6: begin
        we_s = (rd_s != 4'd0);
        b_s  = {{(DATA_W-4){curr_instr[3]}}, curr_instr[3:0]};
      end
      4'h7: begin
        we_s = (rd_s != 4'd0);
        b_s  = {{(DATA_W-8){1'b0}}, curr_instr[7:0]};
      end
      4'h8: begin
        jmp_s    = 1'b1;
        target_s = ADDR_W'(curr_instr[7:0]);
      end
      4'hF: begin
        we_s = 1'b0;
      end
      default: begin
        illegal_s = 1'b1;
      end
    endcase
  end

  // Next-state logic: only an accepted HALT moves to HALTED; only rst leaves it.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      RUN: begin
        if (accept_s && (op_s == 4'hF)) begin
          state_nxt_s = HALTED;
        end else begin
          state_nxt_s = RUN;
        end
      end
      HALTED: begin
        state_nxt_s = HALTED;
      end
      default: begin
        state_nxt_s = RUN;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= RUN;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Register file write port; live in every state, including stall and HALTED.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs_r[i] <= {DATA_W{1'b0}};
      end
    end else if (wb_en && (wb_rd != 4'd0)) begin
      regs_r[wb_rd] <= wb_data;
    end
  end

  // ID/EX register: flush beats accept beats hold beats bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      id_valid_r   <= 1'b0;
      id_op_r      <= 4'd0;
      id_rd_r      <= 4'd0;
      id_a_r       <= {DATA_W{1'b0}};
      id_b_r       <= {DATA_W{1'b0}};
      id_we_r      <= 1'b0;
      id_jmp_r     <= 1'b0;
      id_target_r  <= {ADDR_W{1'b0}};
      id_pc_r      <= {ADDR_W{1'b0}};
      id_illegal_r <= 1'b0;
    end else if (flush) begin
      id_valid_r <= 1'b0;
    end else if (accept_s) begin
      id_valid_r   <= 1'b1;
      id_op_r      <= op_s;
      id_rd_r      <= rd_s;
      id_a_r       <= a_s;
      id_b_r       <= b_s;
      id_we_r      <= we_s;
      id_jmp_r     <= jmp_s;
      id_target_r  <= target_s;
      id_pc_r      <= instr_addr;
      id_illegal_r <= illegal_s;
    end else if (id_valid_r && !ex_ready) begin
      id_valid_r <= id_valid_r;
    end else begin
      id_valid_r <= 1'b0;
    end
  end

  assign id_valid   = id_valid_r;
  assign id_op      = id_op_r;
  assign id_rd      = id_rd_r;
  assign id_a       = id_a_r;
  assign id_b       = id_b_r;
  assign id_we      = id_we_r;
  assign id_jmp     = id_jmp_r;
  assign id_target  = id_target_r;
  assign id_pc      = id_pc_r;
  assign id_illegal = id_illegal_r;
  assign halted     = (state_r == HALTED);

endmodule
